// File: rtl/gobou_post_serial_pkg.sv
// Shared sizing and FSM encodings for the gobou post-processing serialiser.
// Defaults mirror the FC-layer build: 16-bit Q8.8 data, 8 MAC lanes, 12-bit output memory.
package gobou_post_serial_pkg;

  localparam int GB_DWIDTH  = 16;
  localparam int GB_CORE    = 8;
  localparam int NJ_MEMSIZE = 12;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/gobou_post_serial_if.sv
// Group-input and memory-write handshake bundle between the MAC array, this stage and the output memory.
interface gobou_post_serial_if
  import gobou_post_serial_pkg::*;
#(
  parameter int DWIDTH  = GB_DWIDTH,
  parameter int CORE    = GB_CORE,
  parameter int MEMSIZE = NJ_MEMSIZE
) ();

  localparam int NW = $clog2(CORE + 1);

  logic                     in_valid;
  logic                     in_ready;
  logic [CORE*DWIDTH-1:0]   y_in;
  logic [CORE*DWIDTH-1:0]   bias_in;
  logic [NW-1:0]            n_valid;
  logic [MEMSIZE-1:0]       base_addr;
  logic                     relu_en;
  logic                     out_valid;
  logic                     out_ready;
  logic [MEMSIZE-1:0]       out_addr;
  logic [DWIDTH-1:0]        out_data;
  logic                     busy;
  logic                     done;

  modport master (
    output in_valid, y_in, bias_in, n_valid, base_addr, relu_en, out_ready,
    input  in_ready, out_valid, out_addr, out_data, busy, done
  );

  modport slave (
    input  in_valid, y_in, bias_in, n_valid, base_addr, relu_en, out_ready,
    output in_ready, out_valid, out_addr, out_data, busy, done
  );

endinterface

// File: rtl/gobou_post_serial_bias_act.sv
// One lane of post-processing: signed bias add, saturation to DWIDTH bits, optional ReLU.
module gobou_bias_act #(
  parameter int DWIDTH = 16
) (
  input  logic [DWIDTH-1:0] y,
  input  logic [DWIDTH-1:0] bias,
  input  logic              relu_en,
  output logic [DWIDTH-1:0] res
);

  logic [DWIDTH:0]   sum;
  logic [DWIDTH-1:0] sat;

  assign sum = {y[DWIDTH-1], y} + {bias[DWIDTH-1], bias};

  // The top two bits of the widened sum disagree exactly when the result left the DWIDTH range.
  always_comb begin
    sat = sum[DWIDTH-1:0];
    case (sum[DWIDTH:DWIDTH-1])
      2'b01:   sat = {1'b0, {(DWIDTH-1){1'b1}}};
      2'b10:   sat = {1'b1, {(DWIDTH-1){1'b0}}};
      default: sat = sum[DWIDTH-1:0];
    endcase
  end

  assign res = (relu_en && sat[DWIDTH-1]) ? '0 : sat;

endmodule

// File: rtl/gobou_post_serial.sv
// Captures one MAC output group, post-processes each lane and streams the lanes to output memory.
//   state | meaning
//   IDLE  | in_ready high, group buffer loads on in_valid
//   EMIT  | lanes 0..n-1 pushed through the output register under valid/ready
//   DONE  | one-cycle done pulse, then back to IDLE
module gobou_post_serial
  import gobou_post_serial_pkg::*;
#(
  parameter int DWIDTH  = GB_DWIDTH,
  parameter int CORE    = GB_CORE,
  parameter int MEMSIZE = NJ_MEMSIZE
) (
  input  logic                clk,
  input  logic                reset,
  gobou_post_serial_if.slave  bus
);

  localparam int            NW     = $clog2(CORE + 1);
  localparam logic [NW-1:0] CORE_N = NW'(CORE);

  state_t                   state_q, state_d;
  logic [CORE*DWIDTH-1:0]   y_q, bias_q;
  logic [NW-1:0]            n_q, idx_q, n_clamped;
  logic [MEMSIZE-1:0]       base_q, out_addr_q;
  logic                     relu_q;
  logic                     out_valid_q;
  logic [DWIDTH-1:0]        out_data_q;
  logic [DWIDTH-1:0]        lane_y, lane_bias, lane_res;
  logic                     accept, load;

  assign n_clamped = (bus.n_valid > CORE_N) ? CORE_N : bus.n_valid;

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // An empty group still spends one cycle in EMIT, so its done pulse lands two cycles after accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.in_valid) state_d = ST_EMIT;
      ST_EMIT: if (idx_q == n_q && (!out_valid_q || bus.out_ready)) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready = (state_q == ST_IDLE);
    bus.busy     = (state_q != ST_IDLE);
    bus.done     = (state_q == ST_DONE);
    accept       = (state_q == ST_IDLE) && bus.in_valid;
    load         = (state_q == ST_EMIT) && (!out_valid_q || bus.out_ready) && (idx_q < n_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      y_q    <= '0;
      bias_q <= '0;
      n_q    <= '0;
      base_q <= '0;
      relu_q <= 1'b0;
    end else if (accept) begin
      y_q    <= bus.y_in;
      bias_q <= bus.bias_in;
      n_q    <= n_clamped;
      base_q <= bus.base_addr;
      relu_q <= bus.relu_en;
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       idx_q <= '0;
    else if (accept) idx_q <= '0;
    else if (load)   idx_q <= idx_q + 1'b1;
  end

  always_comb begin
    lane_y    = '0;
    lane_bias = '0;
    for (int i = 0; i < CORE; i++) begin
      if (idx_q == NW'(i)) begin
        lane_y    = y_q[i*DWIDTH +: DWIDTH];
        lane_bias = bias_q[i*DWIDTH +: DWIDTH];
      end
    end
  end

  gobou_bias_act #(.DWIDTH(DWIDTH)) u_bias_act (
    .y       (lane_y),
    .bias    (lane_bias),
    .relu_en (relu_q),
    .res     (lane_res)
  );

  // Output register: reloads only when empty or draining, so a stalled word stays put.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_addr_q  <= base_q + MEMSIZE'(idx_q);
      out_data_q  <= lane_res;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_addr  = out_addr_q;
  assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_gobou_post_serial.sv
// Scoreboard bench for gobou_post_serial with CORE=4: table-driven groups plus stall, wrap, empty and reset sequences.
module tb_gobou_post_serial;

  localparam int DW = 16;
  localparam int NC = 4;
  localparam int MS = 12;

  typedef logic [NC-1:0][DW-1:0] lanes_t;
  typedef struct {
    lanes_t y;
    lanes_t b;
    logic   relu;
    lanes_t e;
  } vec_t;
  typedef struct {
    logic [MS-1:0] addr;
    logic [DW-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gobou_post_serial_if #(.DWIDTH(DW), .CORE(NC), .MEMSIZE(MS)) bus ();

  gobou_post_serial #(.DWIDTH(DW), .CORE(NC), .MEMSIZE(MS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t          sbq[$];
  exp_t          mon_e;
  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            grp_writes = 0;
  int            first_hs = -1;
  int            last_hs = -1;
  int            done_count = 0;
  int            done_cyc = -1;
  logic          prev_stall = 1'b0;
  logic [MS-1:0] prev_addr = '0;
  logic [DW-1:0] prev_data = '0;
  vec_t          vtab[5];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [DW-1:0] y, input logic [DW-1:0] b, input logic relu);
    int s;
    s = int'($signed(y)) + int'($signed(b));
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
    if (relu && s < 0) s = 0;
    return DW'(s);
  endfunction

  // Monitor: hold-stability while stalled, scoreboard pop per accepted write, done bookkeeping.
  always @(negedge clk) begin
    if (!reset) begin
      if (prev_stall) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_addr", 32'(bus.out_addr), 32'(prev_addr));
        check("hold_data", 32'(bus.out_data), 32'(prev_data));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (grp_writes == 0) first_hs = cyc;
        last_hs = cyc;
        grp_writes++;
        if (sbq.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL extra_write: got addr %0h data %0h expected no write", bus.out_addr, bus.out_data);
        end else begin
          mon_e = sbq.pop_front();
          check("wr_addr", 32'(bus.out_addr), 32'(mon_e.addr));
          check("wr_data", 32'(bus.out_data), 32'(mon_e.data));
        end
      end
      if (bus.done) begin
        done_count++;
        done_cyc = cyc;
      end
    end
    prev_stall = bus.out_valid && !bus.out_ready && !reset;
    prev_addr  = bus.out_addr;
    prev_data  = bus.out_data;
  end

  task automatic push_model(input lanes_t y, input lanes_t b, input int n, input logic [MS-1:0] base,
                            input logic relu);
    exp_t e;
    for (int i = 0; i < n && i < NC; i++) begin
      e.addr = base + MS'(i);
      e.data = model(y[i], b[i], relu);
      sbq.push_back(e);
    end
  endtask

  task automatic push_table(input vec_t v, input logic [MS-1:0] base);
    exp_t e;
    for (int i = 0; i < NC; i++) begin
      e.addr = base + MS'(i);
      e.data = v.e[i];
      sbq.push_back(e);
    end
  endtask

  // Called at #1 after a rising edge; returns in cycle t+1 with acc = t.
  task automatic start_group(input lanes_t y, input lanes_t b, input logic [2:0] n,
                             input logic [MS-1:0] base, input logic relu, output int acc);
    bus.y_in      = y;
    bus.bias_in   = b;
    bus.n_valid   = n;
    bus.base_addr = base;
    bus.relu_en   = relu;
    bus.in_valid  = 1'b1;
    check("in_ready_idle", 32'(bus.in_ready), 32'd1);
    grp_writes = 0;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    acc = cyc - 1;
    check("no_valid_t1", 32'(bus.out_valid), 32'd0);
  endtask

  task automatic finish_group(input int acc, input int nexp);
    int d0;
    int k;
    d0 = done_count;
    k  = 0;
    while (done_count == d0 && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    if (done_count == d0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got no done pulse expected one within 60 cycles");
    end else begin
      if (nexp > 0) begin
        check("first_latency", 32'(first_hs), 32'(acc + 2));
        check("done_after_last", 32'(done_cyc), 32'(last_hs + 1));
      end else begin
        check("done_empty", 32'(done_cyc), 32'(acc + 2));
      end
      check("write_count", 32'(grp_writes), 32'(nexp));
      check("sb_empty", 32'(sbq.size()), 32'd0);
      check("idle_after_done", 32'(bus.in_ready), 32'd1);
    end
  endtask

  initial begin
    int acc;
    int d0;
    bus.in_valid  = 1'b0;
    bus.y_in      = '0;
    bus.bias_in   = '0;
    bus.n_valid   = '0;
    bus.base_addr = '0;
    bus.relu_en   = 1'b0;
    bus.out_ready = 1'b1;

    vtab[0] = '{y: {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, b: {4{16'h0080}}, relu: 1'b0,
                e: {16'h0100, 16'hFF80, 16'h0280, 16'h0180}};
    vtab[1] = '{y: {16'h0080, 16'hFF00, 16'h0200, 16'h0100}, b: {4{16'h0080}}, relu: 1'b1,
                e: {16'h0100, 16'h0000, 16'h0280, 16'h0180}};
    vtab[2] = '{y: {16'hFFFF, 16'h0000, 16'h8100, 16'h7F00}, b: {16'h0001, 16'h0000, 16'hFE00, 16'h0200},
                relu: 1'b0, e: {16'h0000, 16'h0000, 16'h8000, 16'h7FFF}};
    vtab[3] = '{y: {16'hFFFF, 16'h0000, 16'h8100, 16'h7F00}, b: {16'h0001, 16'h0000, 16'hFE00, 16'h0200},
                relu: 1'b1, e: {16'h0000, 16'h0000, 16'h0000, 16'h7FFF}};
    vtab[4] = '{y: {16'hC000, 16'h4000, 16'h8000, 16'h7FFF}, b: {16'hC000, 16'h4000, 16'h0000, 16'h0000},
                relu: 1'b0, e: {16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF}};

    repeat (3) begin
      @(posedge clk); #1;
    end
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_addr", 32'(bus.out_addr), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int v = 0; v < 5; v++) begin
      push_table(vtab[v], MS'(12'h010 + 12'h020 * v));
      start_group(vtab[v].y, vtab[v].b, 3'd4, MS'(12'h010 + 12'h020 * v), vtab[v].relu, acc);
      check("busy_emit", 32'(bus.busy), 32'd1);
      finish_group(acc, 4);
    end

    // Lane 1 stalled for three cycles.
    push_model(vtab[2].y, vtab[2].b, 4, 12'h200, 1'b0);
    start_group(vtab[2].y, vtab[2].b, 3'd4, 12'h200, 1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("stall_lane1_addr", 32'(bus.out_addr), 32'h201);
    bus.out_ready = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    finish_group(acc, 4);

    // Empty group.
    start_group(vtab[0].y, vtab[0].b, 3'd0, 12'h300, 1'b0, acc);
    finish_group(acc, 0);

    // Address wrap, with in_valid asserted while busy.
    push_model(vtab[4].y, vtab[4].b, 2, 12'hFFF, 1'b0);
    start_group(vtab[4].y, vtab[4].b, 3'd2, 12'hFFF, 1'b0, acc);
    bus.in_valid = 1'b1;
    bus.n_valid  = 3'd4;
    bus.y_in     = '1;
    check("busy_in_ready", 32'(bus.in_ready), 32'd0);
    @(posedge clk); #1;
    check("busy_in_ready2", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    finish_group(acc, 2);

    // n_valid above CORE clamps to CORE.
    push_model(vtab[1].y, vtab[1].b, 4, 12'h100, 1'b1);
    start_group(vtab[1].y, vtab[1].b, 3'd7, 12'h100, 1'b1, acc);
    finish_group(acc, 4);

    // Reset while lane 2 is presented.
    push_model(vtab[0].y, vtab[0].b, 2, 12'h040, 1'b0);
    start_group(vtab[0].y, vtab[0].b, 3'd4, 12'h040, 1'b0, acc);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_lane2", 32'(bus.out_addr), 32'h042);
    d0 = done_count;
    reset = 1'b1;
    bus.out_ready = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    check("rst_mid_busy", 32'(bus.busy), 32'd0);
    reset = 1'b0;
    bus.out_ready = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("rst_mid_no_done", 32'(done_count), 32'(d0));
    check("rst_mid_writes", 32'(grp_writes), 32'd2);
    check("rst_mid_sb", 32'(sbq.size()), 32'd0);

    push_table(vtab[0], 12'h050);
    start_group(vtab[0].y, vtab[0].b, 3'd4, 12'h050, 1'b0, acc);
    finish_group(acc, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
